carpma_birimi: RTL and testbench
================================

CARPMA_BIRIMI -- requirements
Module: carpma_birimi

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 basla_i  input  1  request; held high by execute stage until bitti_o=1 is observed.
REQ-005 islem_i  input  2  00 MUL (low 32, signed x signed), 01 MULH (high 32, signed x signed), 10 MULHSU (high 32, signed x unsigned), 11 MULHU (high 32, unsigned x unsigned).
REQ-006 carpilan_i  input  32  rs1 operand (multiplicand).
REQ-007 carpan_i  input  32  rs2 operand (multiplier).
REQ-008 sonuc_o  output  32  result; valid only in the cycle bitti_o=1 with basla_i=1.
REQ-009 bitti_o  output  1  done/idle flag; low while a multiply is in progress.

Function
REQ-010 SHALL implement a 3-state FSM: BOS (idle), CARP (iterate), SON (deliver).
REQ-011 BOS with basla_i=1: SHALL latch islem_i; latch |carpilan_i| and |carpan_i| as 32-bit unsigned magnitudes; latch sign flag = XOR of operand signs, each sign counted only if that operand is signed for the operation; clear 64-bit accumulator and 4-bit counter; go to CARP.
REQ-012 Magnitude of 0x80000000 SHALL be 0x80000000, treated as unsigned (no overflow).
REQ-013 Operands and islem_i SHALL be sampled only in the BOS->CARP cycle; later changes SHALL NOT affect the result.
REQ-014 CARP SHALL process 2 multiplier bits per cycle (radix-4 shift-add: add 0, 1x, 2x or 3x multiplicand at the current bit position), exactly 16 cycles, then go to SON.
REQ-015 Accumulator arithmetic SHALL be unsigned 64-bit; intermediate sums SHALL NOT lose carries.
REQ-016 SON: if sign flag=1, final product SHALL be the 64-bit two's complement of the magnitude product, else the magnitude product.
REQ-017 SON: sonuc_o SHALL be product[31:0] for MUL and product[63:32] for MULH/MULHSU/MULHU; bitti_o=1; next state BOS.
REQ-018 Latency: basla_i first high in cycle 0 -> bitti_o=1 with valid sonuc_o in cycle 17; back-to-back requests SHALL start in cycle 18 at the earliest.
REQ-019 bitti_o SHALL be 1 when basla_i=0, 0 in BOS-with-basla_i and CARP, 1 in SON.
REQ-020 sonuc_o SHALL be 0 whenever not in SON with basla_i=1.
REQ-021 basla_i dropping to 0 in any state SHALL abort: next state BOS, accumulator and counter cleared, no result delivered.
REQ-022 Operand 0 (either side) SHALL yield 0 for all four operations, sign flag irrelevant.

Reset
REQ-023 rst_ni=0 SHALL immediately force state BOS, clear accumulator, counter, latched operands, islem and sign flag, independent of clk_i.
REQ-024 During and after reset with basla_i=0: bitti_o=1, sonuc_o=0.
REQ-025 Reset asserted mid-CARP SHALL discard the operation; after release with basla_i=1 a fresh multiply SHALL start with full 17-cycle latency.

Verification
REQ-026 MUL 7 x 6 -> cycles 0-16 bitti_o=0, cycle 17 bitti_o=1, sonuc_o=0x0000002A.
REQ-027 MUL/MULH/MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> MUL 0x00000001, MULH 0x00000000, MULHU 0xFFFFFFFE.
REQ-028 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFFFFFF_00000001, sonuc_o=0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-029 MULHU 0x12345678 x 0x0 -> 0x00000000 in cycle 17; operands changed to random values in cycles 1-16 -> result unchanged.
REQ-030 Abort: basla_i low in cycle 5 of a MUL, then high again with 3 x 5 -> 0x0000000F exactly 17 cycles after re-assertion.
REQ-031 rst_ni pulsed low in cycle 8 of a MULH -> bitti_o=1, sonuc_o=0 asynchronously; next request completes with correct result in 17 cycles.

Source files
------------

// File: rtl/carpma_birimi.sv
// carpma_birimi: iterative radix-4 32x32 multiplier for MUL/MULH/MULHSU/MULHU,
// 17-cycle latency from request to result.
module carpma_birimi (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        basla_i,
    input  logic [1:0]  islem_i,
    input  logic [31:0] carpilan_i,
    input  logic [31:0] carpan_i,
    output logic [31:0] sonuc_o,
    output logic        bitti_o
);
    typedef enum logic [1:0] {BOS, CARP, SON} durum_t;
    durum_t      durum_q, durum_d;
    logic [1:0]  islem_q;
    logic [31:0] a_q, b_q;
    logic        isaret_q;
    logic [63:0] acc_q;
    logic [3:0]  sayac_q;
    logic        a_negatif, b_negatif;
    logic [33:0] kat;
    logic [63:0] kismi, carpim;
    // Only operands that are signed for the operation contribute a sign
    assign a_negatif = (islem_i != 2'b11) & carpilan_i[31];
    assign b_negatif = ~islem_i[1] & carpan_i[31];
    assign kat    = (b_q[0] ? {2'b00, a_q} : 34'd0) + (b_q[1] ? {1'b0, a_q, 1'b0} : 34'd0);
    assign kismi  = {30'd0, kat} << {sayac_q, 1'b0};
    assign carpim = isaret_q ? -acc_q : acc_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) durum_q <= BOS;
        else         durum_q <= durum_d;
    end
    always_comb begin
        durum_d = !basla_i ? BOS :
                  durum_q == BOS  ? CARP :
                  durum_q == CARP ? (sayac_q == 4'd15 ? SON : CARP) : BOS;
        bitti_o = !basla_i || durum_q == SON;
        sonuc_o = (basla_i && durum_q == SON) ? (islem_q == 2'b00 ? carpim[31:0] : carpim[63:32]) : 32'd0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            islem_q  <= 2'b00;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            isaret_q <= 1'b0;
            acc_q    <= 64'd0;
            sayac_q  <= 4'd0;
        end else if (!basla_i) begin
            acc_q   <= 64'd0;
            sayac_q <= 4'd0;
        end else if (durum_q == BOS) begin
            islem_q  <= islem_i;
            a_q      <= a_negatif ? -carpilan_i : carpilan_i;
            b_q      <= b_negatif ? -carpan_i : carpan_i;
            isaret_q <= a_negatif ^ b_negatif;
            acc_q    <= 64'd0;
            sayac_q  <= 4'd0;
        end else if (durum_q == CARP) begin
            acc_q   <= acc_q + kismi;
            b_q     <= b_q >> 2;
            sayac_q <= sayac_q + 4'd1;
        end
    end
endmodule

// File: tb/tb_carpma_birimi.sv
// tb_carpma_birimi: directed and random checks of carpma_birimi with a result scoreboard.
module tb_carpma_birimi;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        basla_i = 1'b0;
    logic [1:0]  islem_i = 2'b00;
    logic [31:0] carpilan_i = 32'd0;
    logic [31:0] carpan_i = 32'd0;
    logic [31:0] sonuc_o;
    logic        bitti_o;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] beklenen[$];

    carpma_birimi dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .basla_i(basla_i), .islem_i(islem_i),
        .carpilan_i(carpilan_i), .carpan_i(carpan_i), .sonuc_o(sonuc_o), .bitti_o(bitti_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64, p;
        a64 = (op != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
        b64 = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
        p = a64 * b64;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk_i);
        #1;
        basla_i = 1'b1;
        islem_i = op;
        carpilan_i = a;
        carpan_i = b;
        beklenen.push_back(exp);
    endtask

    // Called in cycle 0 of a request; returns at the sampling point of the done cycle.
    task automatic wait_done(input string tag, input bit scramble);
        int k;
        logic [31:0] exp;
        for (k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (bitti_o) break;
            chk({tag, "_idle_zero"}, sonuc_o, 32'd0);
            @(posedge clk_i);
            #1;
            if (scramble) begin
                carpilan_i = $urandom;
                carpan_i = $urandom;
                islem_i = 2'($urandom_range(0, 3));
            end
        end
        chk({tag, "_latency"}, 32'(k), 32'd17);
        exp = (beklenen.size() > 0) ? beklenen.pop_front() : 32'hDEADBEEF;
        chk(tag, sonuc_o, exp);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk_i);
        #1;
        basla_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_bitti"}, {31'd0, bitti_o}, 32'd1);
        chk({tag, "_sonuc"}, sonuc_o, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        #3;
        chk("reset_bitti", {31'd0, bitti_o}, 32'd1);
        chk("reset_sonuc", sonuc_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        start(2'b00, 32'd7, 32'd6, 32'h0000002A);
        wait_done("mul_7x6", 1'b0);
        start(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        wait_done("mul_m1", 1'b0);
        start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        wait_done("mulh_m1", 1'b0);
        start(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_done("mulhu_m1", 1'b0);
        start(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("mulhsu_m1", 1'b0);
        start(2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        wait_done("mulh_min", 1'b0);
        start(2'b00, 32'h80000000, 32'h00000003, 32'h80000000);
        wait_done("mul_min", 1'b0);
        idle_check("gap");
        start(2'b11, 32'h12345678, 32'h00000000, 32'h00000000);
        wait_done("mulhu_zero_scr", 1'b1);
        start(2'b01, 32'h00000000, 32'h80000001, 32'h00000000);
        wait_done("mulh_zero", 1'b0);
        start(2'b10, 32'h89ABCDEF, 32'hFEDCBA98, model(2'b10, 32'h89ABCDEF, 32'hFEDCBA98));
        wait_done("mulhsu_mix", 1'b1);
        idle_check("after_b2b");
        // Abort in cycle 5, then a fresh request
        start(2'b00, 32'h11111111, 32'h22222222, 32'h0);
        void'(beklenen.pop_back());
        repeat (5) @(posedge clk_i);
        #1;
        basla_i = 1'b0;
        @(negedge clk_i);
        chk("abort_bitti", {31'd0, bitti_o}, 32'd1);
        chk("abort_sonuc", sonuc_o, 32'd0);
        start(2'b00, 32'd3, 32'd5, 32'h0000000F);
        wait_done("mul_after_abort", 1'b0);
        // Reset with request dropped in cycle 8 of a MULH
        start(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
        void'(beklenen.pop_back());
        repeat (8) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        basla_i = 1'b0;
        #1;
        chk("rst_bitti", {31'd0, bitti_o}, 32'd1);
        chk("rst_sonuc", sonuc_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        start(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
        wait_done("mulh_after_rst", 1'b0);
        // Reset glitch between edges with request held: must restart from scratch
        start(2'b00, 32'h00000009, 32'h00000009, 32'h0);
        void'(beklenen.pop_back());
        repeat (8) @(posedge clk_i);
        #1;
        carpilan_i = 32'hFFFFFFFE;
        carpan_i = 32'h00000005;
        beklenen.push_back(32'hFFFFFFF6);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("glitch_sonuc", sonuc_o, 32'd0);
        #1;
        rst_ni = 1'b1;
        wait_done("mul_after_glitch", 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            rop = 2'(i);
            start(rop, ra, rb, model(rop, ra, rb));
            wait_done($sformatf("rand_op%0d", i), 1'b1);
        end
        idle_check("end");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
